mem_stage: RTL

//  Fourth pipeline stage, between EXE and WB. Latches the EXE->MEM bus and waits for the data-SRAM response of any load/store issued in EXE.

---
 rtl/mem_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: waits for data-SRAM responses, extends load data, forwards to WB.
module mem_stage #(
  parameter int EXE_TO_MEM_LEN = 109,
  parameter int MEM_TO_WB_LEN  = 70,
  parameter int MEM_RF_LEN     = 38
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
  input  logic                      EXE_to_MEM_valid,
  output logic                      MEM_allowin,
  input  logic                      WB_allowin,
  output logic                      MEM_to_WB_valid,
  output logic [MEM_TO_WB_LEN-1:0]  MEM_to_WB_BUS,
  output logic [MEM_RF_LEN-1:0]     MEM_RF_BUS,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic                      mem_valid_q;
  state_t                    state_q;
  logic [EXE_TO_MEM_LEN-1:0] bus_q;
  logic [31:0]               rbuf_q;

  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic        mem_en;
  logic [4:0]  load_op;
  logic        rfrom_mem;
  logic        unused_st_data;

  assign rfrom_mem      = bus_q[0];
  assign load_op        = bus_q[5:1];
  assign mem_en         = bus_q[6];
  assign unused_st_data = ^bus_q[38:7];
  assign exe_result     = bus_q[70:39];
  assign dest           = bus_q[75:71];
  assign gr_we          = bus_q[76];
  assign pc             = bus_q[108:77];

  logic need_resp;
  logic ready_go;
  logic accept;
  logic in_need_resp;

  assign need_resp    = mem_valid_q & (rfrom_mem | mem_en);
  assign ready_go     = !need_resp | ((state_q == S_WAIT) & data_sram_data_ok) | (state_q == S_DONE);
  assign MEM_allowin  = !mem_valid_q | (ready_go & WB_allowin);
  assign accept       = EXE_to_MEM_valid & MEM_allowin;
  assign in_need_resp = EXE_to_MEM_BUS[6] | EXE_to_MEM_BUS[0];

  // Next state after a retire depends on whether a new memory op enters at the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      state_q     <= S_IDLE;
      bus_q       <= '0;
      rbuf_q      <= '0;
    end else begin
      if (MEM_allowin) mem_valid_q <= EXE_to_MEM_valid;
      if (accept) bus_q <= EXE_to_MEM_BUS;
      case (state_q)
        S_IDLE: begin
          if (accept && in_need_resp) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (need_resp && data_sram_data_ok) begin
            if (WB_allowin) begin
              state_q <= (accept && in_need_resp) ? S_WAIT : S_IDLE;
            end else begin
              state_q <= S_DONE;
              rbuf_q  <= data_sram_rdata;
            end
          end
        end
        S_DONE: begin
          if (WB_allowin) state_q <= (accept && in_need_resp) ? S_WAIT : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [31:0] rd;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign rd      = (state_q == S_DONE) ? rbuf_q : data_sram_rdata;
  assign rd_half = exe_result[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    rd_byte = rd[7:0];
    case (exe_result[1:0])
      2'd0: rd_byte = rd[7:0];
      2'd1: rd_byte = rd[15:8];
      2'd2: rd_byte = rd[23:16];
      2'd3: rd_byte = rd[31:24];
      default: rd_byte = rd[7:0];
    endcase
  end

  always_comb begin
    load_data = '0;
    if (load_op[0])      load_data = {{24{rd_byte[7]}}, rd_byte};
    else if (load_op[3]) load_data = {24'd0, rd_byte};
    else if (load_op[1]) load_data = {{16{rd_half[15]}}, rd_half};
    else if (load_op[4]) load_data = {16'd0, rd_half};
    else if (load_op[2]) load_data = rd;
  end

  assign final_result    = rfrom_mem ? load_data : exe_result;
  assign MEM_to_WB_valid = mem_valid_q & ready_go;
  assign MEM_to_WB_BUS   = {pc, gr_we, dest, final_result};

  // ID stalls on mem_pending: the result field is not yet meaningful for an unanswered load.
  assign MEM_RF_BUS = {{5{mem_valid_q & gr_we}} & dest,
                       mem_valid_q & rfrom_mem & !ready_go,
                       final_result};

endmodule
